mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single off-chip Data_Memory port (256-bit line, enable/write/ack handshake) between two cache requesters.
  - Requester 0: dcache.
  - Requester 1: icache refill.
- Sits between the caches and Data_Memory. From each cache's side it looks exactly like a private Data_Memory.
- Grants one transaction at a time and holds the grant until memory ack.
- Inserts a one-cycle enable-low turnaround between transactions so the memory FSM re-arms.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache line / memory data width.
- TIMEOUT, 64, cycles in GRANT without mem_ack_i before the error flag sets.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- r0_enable_i  in  1  dcache request; held high until r0_ack_o.
- r0_write_i  in  1  1 = line write, 0 = line read.
- r0_addr_i  in  ADDR_W  byte address of the line.
- r0_data_i  in  LINE_W  write data.
- r0_ack_o  out  1  one-cycle completion pulse.
- r0_data_o  out  LINE_W  read data.
- r1_enable_i, r1_write_i, r1_addr_i, r1_data_i, r1_ack_o, r1_data_o: same as r0, for the icache.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write select.
- mem_addr_o  out  ADDR_W  memory address.
- mem_data_o  out  LINE_W  memory write data.
- mem_ack_i  in  1  memory completion pulse.
- mem_data_i  in  LINE_W  memory read data.
- grant_o  out  2  one-hot owner of the memory port; 00 when idle.
- timeout_err_o  out  1  sticky error flag.

Behaviour:
- States: IDLE, GRANT.
- Reset (rst_i high at a clock edge):
  - state = IDLE; grant_o = 00.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - timeout_err_o = 0; wait counter = 0; last-grant = requester 1.
  - Reset mid-transaction abandons it: no requester ack is issued. Data_Memory shares rst_i.
- IDLE:
  - If any rX_enable_i is high, pick a winner (see Optional Feature).
  - Register the winner's write, addr and data into the mem_* outputs.
  - Set grant_o to the winner; mem_enable_o = 1; go to GRANT.
  - Latency: request sampled at edge t gives mem_enable_o high after edge t.
- GRANT:
  - mem_* outputs hold constant; the captured copy is used even if the requester changes its inputs.
  - Wait counter increments each cycle.
  - When the counter reaches TIMEOUT, timeout_err_o sets and stays set until reset. The transaction is not aborted.
  - On mem_ack_i:
    - rX_ack_o = mem_ack_i & grant_o[X] & (state == GRANT), combinational, same cycle.
    - Next edge: mem_enable_o = 0, grant_o = 00, counter = 0, go to IDLE.
- Turnaround: the IDLE cycle after an ack always has mem_enable_o low.
  - A back-to-back request gets its new grant one edge after that cycle.
  - Ack at cycle t gives enable low in t+1 and enable high in t+2.
- rX_data_o = mem_data_i for both requesters (broadcast). Only the ack qualifies the data.
- mem_ack_i seen in IDLE is ignored; no rX_ack_o is produced.
- A requester that drops enable before its ack is a protocol violation. The transaction still completes and the ack pulse is still driven.
- A losing requester stays pending with no time limit; no request is ever dropped.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests, grant the requester that is not last-grant.
  - last-grant updates on every grant.
- Undefined: fixed priority.
  - r0 (dcache) always wins ties.
  - No last-grant register; r1 may starve under continuous r0 traffic, which is accepted.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - requester index constants REQ_DCACHE = 0, REQ_ICACHE = 1;
  - default ADDR_W, LINE_W, TIMEOUT.
- Sub-module mem_arb_pick: purely combinational winner select from {r0_enable_i, r1_enable_i, last_grant}. It holds the MEM_ARB_RR_EN conditional.
- mem_arbiter holds the FSM, the capture registers, the timeout counter and the ack routing.

Test Plan:
- The bench memory model acks exactly 10 cycles after mem_enable_o rises.
- Test 1, single read:
  - Stimulus: r0 reads addr 0x0000_0020.
  - Response: mem_addr_o = 0x20 and mem_write_o = 0 one edge later; r0_ack_o pulses once; r0_data_o = the line at 0x20; r1_ack_o never asserts.
- Test 2, simultaneous requests:
  - Stimulus: r0 writes 0x200 while r1 reads 0x400.
  - Response: r0 is served first.
    - Without MEM_ARB_RR_EN, r0 keeps winning while it re-requests.
    - With MEM_ARB_RR_EN, the grant alternates r0, r1, r0, r1 over 4 transactions.
- Test 3, turnaround:
  - Stimulus: r1 requests while r0's transaction is in flight.
  - Response: mem_enable_o is low for exactly one cycle after r0's ack, then high with mem_addr_o = r1's address.
- Test 4, input change during GRANT:
  - Stimulus: change r0_addr_i from 0x40 to 0x60 mid-GRANT.
  - Response: mem_addr_o stays 0x40 until the ack.
- Test 5, timeout:
  - Stimulus: the memory model withholds ack for 70 cycles.
  - Response: timeout_err_o rises on GRANT cycle 64 and stays high after the late ack; the ack is still routed.
- Test 6, reset mid-transaction:
  - Stimulus: assert rst_i for 1 cycle 5 cycles into GRANT.
  - Response: next edge gives mem_enable_o = 0, grant_o = 00, timeout_err_o = 0; no rX_ack_o pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester Data_Memory arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Requester indices; also the encoding of the last-grant bit.
  localparam int unsigned REQ_DCACHE = 0;
  localparam int unsigned REQ_ICACHE = 1;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned LINE_W_DEF  = 256;
  localparam int unsigned TIMEOUT_DEF = 64;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the dcache and icache requesters.
// Build option: MEM_ARB_RR_EN selects round-robin on ties; otherwise the
// dcache always wins ties and last_grant_i is ignored.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       r0_req_i,
  input  logic       r1_req_i,
  input  logic       last_grant_i,
  output logic [1:0] win_o
);

`ifdef MEM_ARB_RR_EN
  // Tie goes to whichever requester was not granted last.
  always_comb begin
    win_o = {r1_req_i, r0_req_i};
    if (r0_req_i && r1_req_i) begin
      win_o = (last_grant_i == 1'(REQ_ICACHE)) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  // Fixed priority: dcache masks icache.
  always_comb begin
    win_o = {r1_req_i & ~r0_req_i, r0_req_i};
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Data_Memory port between dcache (r0) and icache refill (r1).
// One transaction at a time, grant held until mem_ack_i, one enable-low
// turnaround cycle between transactions, sticky timeout flag.
// Build option: MEM_ARB_RR_EN enables round-robin tie breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [LINE_W-1:0] r0_data_i,
  output logic              r0_ack_o,
  output logic [LINE_W-1:0] r0_data_o,
  input  logic              r1_enable_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [LINE_W-1:0] r1_data_i,
  output logic              r1_ack_o,
  output logic [LINE_W-1:0] r1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              timeout_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q;
  logic [1:0]        grant_q;
  logic              mem_enable_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_data_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic              timeout_err_q;
  logic              last_grant;
  logic [1:0]        win;
  logic              in_grant;

  mem_arb_pick u_pick (
    .r0_req_i     (r0_enable_i),
    .r1_req_i     (r1_enable_i),
    .last_grant_i (last_grant),
    .win_o        (win)
  );

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;

  // Remember who won the most recent grant for tie breaking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'(REQ_ICACHE);
    end else if (state_q == IDLE && win != 2'b00) begin
      last_grant_q <= win[1];
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'(REQ_ICACHE);
`endif

  // Saturating wait counter so it never wraps past the timeout value.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (wait_cnt_q != CNT_W'(TIMEOUT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Arbiter FSM with captured request and registered memory-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      mem_enable_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win != 2'b00) begin
            state_q      <= GRANT;
            grant_q      <= win;
            mem_enable_q <= 1'b1;
            mem_write_q  <= win[1] ? r1_write_i : r0_write_i;
            mem_addr_q   <= win[1] ? r1_addr_i  : r0_addr_i;
            mem_data_q   <= win[1] ? r1_data_i  : r0_data_i;
          end
        end
        GRANT: begin
          wait_cnt_q <= wait_cnt_d;
          if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
            timeout_err_q <= 1'b1;
          end
          if (mem_ack_i) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            mem_enable_q <= 1'b0;
            wait_cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ack routed to the owner only while a grant is live; data is broadcast.
  assign in_grant      = (state_q == GRANT);
  assign r0_ack_o      = mem_ack_i & grant_q[0] & in_grant;
  assign r1_ack_o      = mem_ack_i & grant_q[1] & in_grant;
  assign r0_data_o     = mem_data_i;
  assign r1_data_o     = mem_data_i;

  assign mem_enable_o  = mem_enable_q;
  assign mem_write_o   = mem_write_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign grant_o       = grant_q;
  assign timeout_err_o = timeout_err_q;

endmodule
